// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// LOADER_CHECKSUM_EN (see instr_mem_loader.sv) adds the trailing checksum stage.
package instr_mem_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned BYTE_IDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host-side control, byte stream and instruction memory write bus of the loader.
// slave = loader side, master = host / memory side.
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// Assembles accepted stream bytes into a little-endian instruction word.
// Byte k of a word ends up in bits [8k+7:8k] once all bytes have shifted in.
module loader_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          accept_i,
  input  logic [7:0]                    byte_i,
  output logic                          last_byte_o,
  output logic                          word_full_o,
  output logic [8*BYTES_PER_WORD-1:0]   word_o
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  full_q, full_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    full_d = full_q;
    if (clear_i) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else if (accept_i) begin
      // New bytes enter at the top so the first byte finishes in the low lane.
      word_d = {byte_i, word_q[WORD_W-1:8]};
      idx_d  = idx_q + 1'b1;
      full_d = full_q | (idx_q == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign last_byte_o = (idx_q == LAST_IDX);
  assign word_full_o = full_q;
  assign word_o      = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Fills instruction memory from a byte stream while holding the CPU in reset.
// Optional macro LOADER_CHECKSUM_EN: a trailing mod-256 checksum byte is verified.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
)(
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic byte_ready;
  logic imem_we;
  logic pk_clear, pk_accept, pk_last, pk_full;
  logic [8*BYTES_PER_WORD-1:0] pk_word;

  loader_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .accept_i    (pk_accept),
    .byte_i      (bus.byte_data),
    .last_byte_o (pk_last),
    .word_full_o (pk_full),
    .word_o      (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    error_d    = error_q;
    pk_clear   = 1'b0;
    pk_accept  = 1'b0;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          error_d    = 1'b0;
          word_idx_d = '0;
          pk_clear   = 1'b1;
          last_idx_d = ADDR_WIDTH'(bus.word_count - 1'b1);
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          if (bus.word_count == '0) begin
            state_d = ST_DONE;
          end else if (bus.word_count > DEPTH) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          pk_accept = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + bus.byte_data;
`endif
          if (pk_last) state_d = ST_COLLECT == ST_COLLECT ? ST_WRITE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        imem_we  = pk_full;
        pk_clear = 1'b1;
        if (word_idx_q == last_idx_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = ST_COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          error_d = (bus.byte_data != sum_q);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of where the FSM is heading.
    done_d = (state_d == ST_DONE);
    hold_d = !((state_d == ST_DONE) && !error_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      last_idx_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      done_q     <= done_d;
      error_q    <= error_d;
      hold_q     <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = word_idx_q;
  assign bus.imem_wdata = DATA_WIDTH'(pk_word);
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: randomized byte streams checked
// against expected little-endian words, addresses, write timing and status.
module tb_instr_mem_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cyc, start_cyc, hold_viol, rdy_we_viol, n_offered;
  bit timed_out;
  logic [7:0]  byte_q[$], exp_b[$], acc_byte[$];
  int          acc_cyc[$], obs_addr[$], obs_cyc[$];
  logic [31:0] obs_data[$];
  logic [7:0]  plan [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h86, 8'h20, 8'h00};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Builds the byte stream for an n-word load and clears all observations.
  task automatic prep(input int n, input bit fixed);
    logic [7:0] b;
    byte_q.delete(); exp_b.delete(); acc_byte.delete(); acc_cyc.delete();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    hold_viol = 0; rdy_we_viol = 0; done_cyc = -1; timed_out = 0;
    for (int i = 0; i < 4 * n; i++) begin
      b = fixed ? plan[i % 8] : 8'($urandom);
      byte_q.push_back(b);
      exp_b.push_back(b);
    end
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      logic [7:0] s;
      s = 8'h00;
      foreach (exp_b[i]) s = s + exp_b[i];
      byte_q.push_back(s);
    end
`endif
    n_offered = byte_q.size();
  endtask

  task automatic do_start(input int n);
    bus.start      = 1'b1;
    bus.word_count = n[AW:0];
    bus.byte_valid = 1'b0;
    step();
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: valid always, 1: every other cycle, 2: random. Records only.
  task automatic run_stream(input int mode, input int stop_after, input int max_cycles);
    bit fin, v;
    fin = 0;
    for (int c = 0; c < max_cycles && !fin; c++) begin
      if (bus.imem_we === 1'b1) begin
        obs_addr.push_back(int'(bus.imem_addr));
        obs_data.push_back(bus.imem_wdata);
        obs_cyc.push_back(cyc);
        if (bus.byte_ready !== 1'b0) rdy_we_viol++;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        fin = 1;
      end else if (stop_after > 0 && acc_byte.size() >= stop_after) begin
        fin = 1;
      end else begin
        if (bus.cpu_hold !== 1'b1) hold_viol++;
        case (mode)
          0:       v = 1'b1;
          1:       v = (c % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        v = v && (byte_q.size() > 0);
        bus.byte_valid = v;
        bus.byte_data  = v ? byte_q[0] : 8'($urandom);
        if (v && bus.byte_ready === 1'b1) begin
          acc_byte.push_back(byte_q.pop_front());
          acc_cyc.push_back(cyc);
        end
        step();
      end
    end
    bus.byte_valid = 1'b0;
    if (!fin) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.word_count = '0; bus.byte_valid = 1'b0; bus.byte_data = '0;
    repeat (3) step();
    n_cmp++;
    if ({bus.byte_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/we/hold/done/err=%b want 00100",
               {bus.byte_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error});
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({bus.byte_ready, bus.cpu_hold, bus.done} !== 3'b010) begin
      n_fail++;
      $display("FAIL idle_outputs: got rdy/hold/done=%b want 010", {bus.byte_ready, bus.cpu_hold, bus.done});
    end
  endtask

  task automatic test_basic_load();
    logic [31:0] exp_w [2] = '{32'h00100513, 32'h00208633};
    int exp_done;
    prep(2, 1'b1);
    do_start(2);
    run_stream(0, 0, 200);
    n_cmp++;
    if (timed_out || obs_addr.size() != 2) begin
      n_fail++;
      $display("FAIL basic_nwrites: got %0d writes (timeout=%0d) want 2", obs_addr.size(), timed_out);
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_w[i] || obs_addr[i] != i) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], exp_w[i], i);
      end
      n_cmp++;
      if (obs_cyc[i] != acc_cyc[4*i+3] + 1) begin
        n_fail++;
        $display("FAIL basic_latency%0d: write at %0d want %0d", i, obs_cyc[i], acc_cyc[4*i+3] + 1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 1 : -2;
`else
    exp_done = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] + 1 : -2;
`endif
    n_cmp++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL basic_done_time: done at %0d want %0d", done_cyc, exp_done);
    end
    n_cmp++;
    if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100 || hold_viol != 0 || rdy_we_viol != 0) begin
      n_fail++;
      $display("FAIL basic_status: done/hold/err=%b hold_viol=%0d rdy_we=%0d want 100 0 0",
               {bus.done, bus.cpu_hold, bus.error}, hold_viol, rdy_we_viol);
    end
  endtask

  task automatic test_valid_toggle();
    logic [31:0] w;
    prep(2, 1'b1);
    do_start(2);
    run_stream(1, 0, 300);
    n_cmp++;
    if (timed_out || obs_addr.size() != 2) begin
      n_fail++;
      $display("FAIL toggle_nwrites: got %0d writes (timeout=%0d) want 2", obs_addr.size(), timed_out);
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      w = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
      n_cmp++;
      if (obs_data[i] !== w || obs_addr[i] != i || obs_cyc[i] != acc_cyc[4*i+3] + 1) begin
        n_fail++;
        $display("FAIL toggle_word%0d: got %h@%0d t=%0d want %h@%0d t=%0d", i, obs_data[i], obs_addr[i],
                 obs_cyc[i], w, i, acc_cyc[4*i+3] + 1);
      end
    end
    n_cmp++;
    if (acc_byte.size() != n_offered) begin
      n_fail++;
      $display("FAIL toggle_accept_count: got %0d want %0d", acc_byte.size(), n_offered);
    end
    for (int i = 0; i < exp_b.size() && i < acc_byte.size(); i++) begin
      n_cmp++;
      if (acc_byte[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL toggle_byte%0d: got %h want %h", i, acc_byte[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (rdy_we_viol != 0) begin
      n_fail++;
      $display("FAIL toggle_ready_in_write: got %0d cycles want 0", rdy_we_viol);
    end
  endtask

  task automatic test_random_loads();
    int n;
    logic [31:0] w;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      prep(n, 1'b0);
      do_start(n);
      run_stream(2, 0, 1000);
      n_cmp++;
      if (timed_out || obs_addr.size() != n) begin
        n_fail++;
        $display("FAIL rand%0d_nwrites: got %0d (timeout=%0d) want %0d", it, obs_addr.size(), timed_out, n);
      end
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
        w = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
        n_cmp++;
        if (obs_data[i] !== w || obs_addr[i] != i) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: got %h@%0d want %h@%0d", it, i, obs_data[i], obs_addr[i], w, i);
        end
      end
      n_cmp++;
      if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100 || hold_viol != 0) begin
        n_fail++;
        $display("FAIL rand%0d_status: done/hold/err=%b hold_viol=%0d want 100 0", it,
                 {bus.done, bus.cpu_hold, bus.error}, hold_viol);
      end
    end
  endtask

  task automatic test_zero_and_overflow();
    int cnt [3];
    cnt[0] = 0; cnt[1] = DEPTH + 1; cnt[2] = $urandom_range(DEPTH + 2, 2 * DEPTH - 1);
    for (int k = 0; k < 3; k++) begin
      prep(0, 1'b0);
      do_start(cnt[k]);
      run_stream(0, 0, 20);
      n_cmp++;
      if (timed_out || done_cyc != start_cyc || obs_addr.size() != 0) begin
        n_fail++;
        $display("FAIL count%0d_done: done_at=%0d writes=%0d want done_at=%0d writes=0", cnt[k], done_cyc,
                 obs_addr.size(), start_cyc);
      end
      n_cmp++;
      if ({bus.error, bus.cpu_hold} !== ((k == 0) ? 2'b00 : 2'b11)) begin
        n_fail++;
        $display("FAIL count%0d_status: err/hold=%b want %b", cnt[k], {bus.error, bus.cpu_hold},
                 (k == 0) ? 2'b00 : 2'b11);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w;
    prep(3, 1'b0);
    do_start(3);
    run_stream(0, 6, 200);
    reset = 1'b1;
    step();
    n_cmp++;
    if ({bus.cpu_hold, bus.byte_ready, bus.done, bus.imem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_outputs: hold/rdy/done/we=%b want 1000",
               {bus.cpu_hold, bus.byte_ready, bus.done, bus.imem_we});
    end
    w = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] != 0 || obs_data[0] !== w) begin
      n_fail++;
      $display("FAIL midreset_writes: got %0d writes first=%h want 1 write %h@0", obs_addr.size(), obs_data[0], w);
    end
    reset = 1'b0;
    step();
    prep(1, 1'b0);
    do_start(1);
    run_stream(2, 0, 200);
    w = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    n_cmp++;
    if (timed_out || obs_addr.size() != 1 || obs_addr[0] != 0 || obs_data[0] !== w) begin
      n_fail++;
      $display("FAIL reload_word: got %0d writes %h@%0d want 1 write %h@0", obs_addr.size(), obs_data[0],
               obs_addr[0], w);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    prep(2, 1'b0);
    do_start(2);
    run_stream(0, 2, 100);
    bus.start = 1'b1;
    bus.word_count = 6'd1;
    step();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_start_ready: got %b want 1", bus.byte_ready);
    end
    run_stream(0, 0, 200);
    n_cmp++;
    if (timed_out || obs_addr.size() != 2 || acc_byte.size() != n_offered) begin
      n_fail++;
      $display("FAIL ignored_start_counts: writes=%0d accepted=%0d want 2 %0d", obs_addr.size(),
               acc_byte.size(), n_offered);
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      w = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
      n_cmp++;
      if (obs_data[i] !== w || obs_addr[i] != i) begin
        n_fail++;
        $display("FAIL ignored_start_word%0d: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], w, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int bad;
    prep(0, 1'b0);
    do_start(DEPTH + 1);
    run_stream(0, 0, 20);
    prep(1, 1'b0);
    do_start(1);
    n_cmp++;
    if ({bus.done, bus.error} !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_clear: done/err=%b want 00", {bus.done, bus.error});
    end
    run_stream(0, 0, 100);
    w = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
    n_cmp++;
    if (timed_out || obs_addr.size() != 1 || obs_data[0] !== w || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_word: writes=%0d got %h err=%b want 1 %h 0", obs_addr.size(), obs_data[0],
               bus.error, w);
    end
    prep(DEPTH, 1'b0);
    do_start(DEPTH);
    run_stream(2, 0, 3000);
    bad = 0;
    for (int i = 0; i < DEPTH && i < obs_addr.size(); i++) begin
      w = {exp_b[4*i+3], exp_b[4*i+2], exp_b[4*i+1], exp_b[4*i]};
      if (obs_data[i] !== w || obs_addr[i] != i) bad++;
    end
    n_cmp++;
    if (timed_out || obs_addr.size() != DEPTH || bad != 0) begin
      n_fail++;
      $display("FAIL full_depth: writes=%0d bad_words=%0d want %0d 0", obs_addr.size(), bad, DEPTH);
    end
    n_cmp++;
    if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_depth_status: done/hold/err=%b want 100", {bus.done, bus.cpu_hold, bus.error});
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < 2; k++) begin
      prep(0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
        byte_q.push_back(8'(i));
        exp_b.push_back(8'(i));
      end
      byte_q.push_back(8'h0A + 8'(k));
      do_start(1);
      run_stream(0, 0, 100);
      n_cmp++;
      if (timed_out || obs_addr.size() != 1 || obs_data[0] !== 32'h04030201) begin
        n_fail++;
        $display("FAIL checksum%0d_word: writes=%0d got %h want 1 04030201", k, obs_addr.size(), obs_data[0]);
      end
      n_cmp++;
      if ({bus.done, bus.error, bus.cpu_hold} !== {1'b1, (k == 1), (k == 1)}) begin
        n_fail++;
        $display("FAIL checksum%0d_status: done/err/hold=%b want %b", k, {bus.done, bus.error, bus.cpu_hold},
                 {1'b1, (k == 1), (k == 1)});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_random_loads();
    test_zero_and_overflow();
    test_reset_midload();
    test_start_ignored();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction fetch path: fills instruction memory from a byte stream before the processor runs.
- Accepts bytes on a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the processor core in reset through cpu_hold until the load completes.

Parameters:
- ADDR_WIDTH, 5, instruction memory word-address width; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin load, honoured only in IDLE or DONE
- word_count  in  ADDR_WIDTH+1  words to load; sampled on start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  processor reset/hold request
- done  out  1  load finished (level)
- error  out  1  load failed (level)

Behaviour:
- Reset: one clock domain; reset is synchronous and active-high on port reset; clock port is clk.
  - All outputs are 0 except cpu_hold=1.
  - FSM goes to IDLE; byte counter, word counter and shift register are cleared.
- FSM states: IDLE, COLLECT, WRITE, CHECK (only with the optional feature), DONE.
- IDLE: cpu_hold=1, byte_ready=0. On start, latch word_count as N.
  - N==0 -> DONE, error=0.
  - N>DEPTH -> DONE, error=1, no writes.
  - Otherwise -> COLLECT with word_idx=0, byte_idx=0.
- COLLECT: byte_ready=1.
  - A byte is accepted only when byte_valid&&byte_ready.
  - byte k of a word (k=0..3) lands in bits [8k+7:8k]; byte_idx increments per accepted byte.
  - On accepting byte 3 -> WRITE.
  - byte_valid low simply stalls; there is no timeout.
- WRITE (exactly one cycle): imem_we=1, imem_addr=word_idx, imem_wdata=assembled word, byte_ready=0.
  - The write occurs the cycle after the 4th byte is accepted.
  - Next state: word_idx==N-1 -> DONE (or CHECK); else word_idx++, byte_idx=0, -> COLLECT.
- Throughput: at most 1 word per 5 cycles.
- DONE: done=1, cpu_hold=0, byte_ready=0; the FSM stays here.
  - start -> restart the load as from IDLE; done and error clear in the cycle the start is accepted.
- start in COLLECT/WRITE/CHECK is ignored.
- Bytes offered outside COLLECT/CHECK are not accepted (byte_ready=0).
- imem_we is never asserted outside WRITE. imem_addr/imem_wdata are don't-care when imem_we=0 but are held stable (registered).
- Reset mid-load returns the FSM to IDLE with cpu_hold=1. Words already written stay in memory; a partial word is discarded.
- word_idx never wraps, because N<=DEPTH is enforced on start.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) covers every accepted data byte.
  - After the last WRITE -> CHECK: byte_ready=1, accept exactly one byte.
  - error=1 if that byte != sum; then -> DONE. done asserts either way.
  - cpu_hold stays 1 in DONE when error=1.
  - The sum clears on start.
- Undefined: no CHECK state and no sum register; WRITE goes directly to DONE; error is set only for N>DEPTH.

Decomposition:
- Shared package: FSM state enum (IDLE, COLLECT, WRITE, CHECK, DONE), BYTES_PER_WORD=4, default ADDR_WIDTH.
- One natural sub-module: loader_word_packer. It holds byte_idx, the 32-bit shift/assemble register and a word_full flag; the FSM and address counter stay in the top module.

Test Plan:
- Load N=2 with bytes 13 05 10 00, 33 86 20 00 (byte_valid held high) -> writes 0x00100513 @0 and 0x00208633 @1, each exactly 1 cycle after its 4th byte; done=1 and cpu_hold=0 the cycle after the 2nd write.
- Same load with byte_valid toggling every other cycle -> identical writes and data; no byte duplicated or dropped; byte_ready=0 during WRITE.
- N=0 -> done=1 the next cycle, no imem_we. N=DEPTH+1 (33) -> error=1, done=1, no imem_we, cpu_hold stays 1.
- Reset asserted after 6 bytes of an N=3 load -> next cycle IDLE, cpu_hold=1, only word 0 written. A subsequent start with N=1 loads correctly at address 0.
- start pulsed during COLLECT -> ignored; word_idx and byte_idx are unchanged.
- LOADER_CHECKSUM_EN, N=1, bytes 01 02 03 04, check byte 0x0A -> error=0, done=1. Check byte 0x0B -> error=1, done=1, cpu_hold=1.
